mem_bus_stage: RTL and testbench
================================

// Module: mem_bus_stage
// PURPOSE
//  Memory-access (MEM) stage between ex_mem and mem_wb. Non-memory ops pass straight through to the mem_* outputs that feed mem_wb.
//  Loads/stores run a single-transfer data-bus cycle (stb/ack handshake), holding the pipeline via stallreq until the bus acks.
//  Loads are lane-selected and sign/zero-extended (big-endian lanes); HI/LO results pass through untouched.
// PARAMETERS
//  ACK_TIMEOUT  256  bus cycles waited for ack before abandoning the transfer; 0 = wait forever
// PORTS
//  clk         in   1   clock
//  rst         in   1   reset, synchronous, active-high
//  flush       in   1   pipeline flush; kills the current op
//  ex_wd       in   5   destination register address
//  ex_wreg     in   1   register write enable
//  ex_wdata    in   32  ALU result (non-load ops)
//  ex_hi/ex_lo in   32  HI/LO result
//  ex_whilo    in   1   HI/LO write enable
//  ex_aluop    in   8   op code (LB/LBU/LH/LHU/LW/SB/SH/SW as in defines.v)
//  ex_mem_addr in   32  effective address
//  ex_reg2     in   32  store data
//  mem_wd/mem_wreg/mem_wdata/mem_hi/mem_lo/mem_whilo  out  5/1/32/32/32/1  to mem_wb
//  stallreq    out  1   stall request to the pipeline controller
//  bus_addr    out  32  word address ({addr[31:2],2'b00})
//  bus_wdata   out  32  store data replicated to lanes
//  bus_we      out  1   1 = write
//  bus_sel     out  4   byte enables; sel[3] = bits[31:24] = addr 00
//  bus_stb     out  1   request valid; held until ack
//  bus_ack     in   1   transfer complete (rdata valid on loads)
//  bus_rdata   in   32  read data
//  bus_err     out  1   1-cycle pulse on timeout (or misalignment, see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; bus_stb=0, bus_we=0, bus_sel=0, bus_addr=0, bus_wdata=0, bus_err=0, rdata_q=0.
//   While rst=1, mem_* = 0/NOPRegAddr/WriteDisable and stallreq=0 (combinational gating).
//  FSM IDLE -> REQ -> DONE -> IDLE; ABORT on flush/timeout.
//  IDLE, non-mem op: mem_* = ex_* combinationally; stallreq=0; 0-cycle latency.
//  IDLE, mem op, flush=0: stallreq=1, mem_wreg=0; next edge registers bus_addr/we/sel/wdata, bus_stb=1 -> REQ.
//  REQ: stb/addr/we/sel/wdata stable; stallreq=1. On ack: stb=0, rdata_q<=bus_rdata -> DONE.
//   Ack in the first REQ cycle is legal (min latency: IDLE, REQ, DONE = 3 cycles).
//  DONE: stallreq=0; loads: mem_wdata=extend(rdata_q), mem_wreg=ex_wreg; stores: mem_wreg=0. -> IDLE next edge.
//  Lanes: SB/LB(U) sel=1000>>addr[1:0]; SH/LH(U) sel=1100 (addr[1]=0) or 0011.
//   SW/LW sel=1111. LB sign-extends, LBU zero-extends; LH/LHU likewise on the 16-bit lane.
//  Store data: SB {4{b}}, SH {2{h}}, SW word.
//  Timeout: counter clears on REQ entry and counts REQ cycles. At ACK_TIMEOUT-1 with no ack:
//   stb=0, bus_err pulse, -> DONE with mem_wreg forced 0.
//  flush in IDLE: no bus cycle, mem_wreg=mem_whilo=0.
//  flush in REQ: -> ABORT; stb stays 1 until ack (no transfer abandoned mid-cycle); data discarded.
//   Then IDLE, no writeback.
//  flush in DONE: writeback suppressed; -> IDLE.
//  ABORT: stallreq=1 until ack.
//  Simultaneous ack+flush in REQ: transfer complete, data discarded, -> IDLE.
//  rst mid-transfer: stb dropped at once; the bus tolerates an orphan ack (ignored in IDLE).
// CONFIGURATION
//  MEM_ALIGN_CHK_EN defined: LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0:
//   no bus cycle; bus_err pulses 1 cycle; mem_wreg=0; stallreq=0; stay IDLE.
//  Undefined: low address bits ignored as above (SH/LH use addr[1]; LW/SW force word-aligned); bus_err only on timeout.
// TESTING
//  ADD op, ex_wdata=0x1234 -> same-cycle mem_wdata=0x1234, stallreq=0, no bus_stb.
//  LB addr=0x101, ack after 2 cycles, rdata=0x00F00000 -> sel=0100, mem_wdata=0xFFFFFFF0, stall 3 cycles.
//  SH addr=0x202, reg2=0xABCD -> we=1, sel=0011, wdata=0xABCDABCD, addr=0x200, mem_wreg=0.
//  LW with flush in 2nd REQ cycle, ack later -> stb held to ack, no writeback, back to IDLE.
//  ACK_TIMEOUT=4, LW, ack never -> stb low after 4 REQ cycles, bus_err pulse, mem_wreg=0.
//  MEM_ALIGN_CHK_EN: LW addr=0x3 -> no stb, bus_err=1 one cycle, stallreq=0.

Source files
------------

// File: rtl/mem_bus_stage_if.sv
// Data-bus port bundle between the MEM stage (master) and the memory fabric (slave).
// Handshake: master raises bus_stb with addr/we/sel/wdata stable and holds them until the
// slave answers with a one-cycle bus_ack; on reads bus_rdata is valid in that ack cycle.
interface mem_bus_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic        bus_stb;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_err;

    modport master (
        output bus_addr, bus_wdata, bus_we, bus_sel, bus_stb, bus_err,
        input  bus_ack, bus_rdata
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_we, bus_sel, bus_stb, bus_err,
        output bus_ack, bus_rdata
    );
endinterface

// File: rtl/mem_bus_stage.sv
// MEM pipeline stage: passes non-memory ops through and runs one stb/ack bus transfer per load/store.
// Optional macro MEM_ALIGN_CHK_EN rejects misaligned halfword/word accesses with a bus_err pulse.
module mem_bus_stage #(
    parameter int unsigned ACK_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_reg2,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic        stallreq,
    output logic [1:0]  dbg_state_o,
    mem_bus_if.master   bus
);
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    localparam logic [1:0] SZ_NONE = 2'd0;
    localparam logic [1:0] SZ_B    = 2'd1;
    localparam logic [1:0] SZ_H    = 2'd2;
    localparam logic [1:0] SZ_W    = 2'd3;

    localparam int CW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, ABORT = 2'd3} state_t;

    function automatic logic [1:0] op_size(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_B;
            OP_LH, OP_LHU, OP_SH: return SZ_H;
            OP_LW, OP_SW:         return SZ_W;
            default:              return SZ_NONE;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [7:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) || (op == OP_LHU) || (op == OP_LW);
    endfunction

    state_t        state_q, state_d;
    logic          stb_q, stb_d;
    logic [31:0]   addr_q, addr_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [7:0]    op_q, op_d;
    logic [1:0]    alo_q, alo_d;

    logic [1:0]  ex_size;
    logic        is_mem;
    logic        misalign;
    logic        timeout_hit;
    logic [3:0]  lane_sel;
    logic [31:0] st_data;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic        ld_signed;
    logic [31:0] ld_data;
    logic        stall;
    logic        wb_wreg;
    logic        wb_whilo;
    logic [31:0] wb_wdata;

    assign ex_size     = op_size(ex_aluop);
    assign is_mem      = (ex_size != SZ_NONE);
    assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

`ifdef MEM_ALIGN_CHK_EN
    assign misalign = ((ex_size == SZ_H) && ex_mem_addr[0]) ||
                      ((ex_size == SZ_W) && (ex_mem_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif

    // Big-endian lanes: byte address 0 lives in bits [31:24], so sel[3] is the lowest address.
    always_comb begin
        lane_sel = 4'b1111;
        st_data  = ex_reg2;
        case (ex_size)
            SZ_B: begin
                lane_sel = 4'b1000 >> ex_mem_addr[1:0];
                st_data  = {4{ex_reg2[7:0]}};
            end
            SZ_H: begin
                lane_sel = ex_mem_addr[1] ? 4'b0011 : 4'b1100;
                st_data  = {2{ex_reg2[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_v = rdata_q[31:24];
        case (alo_q)
            2'd1:    byte_v = rdata_q[23:16];
            2'd2:    byte_v = rdata_q[15:8];
            2'd3:    byte_v = rdata_q[7:0];
            default: ;
        endcase
        half_v    = alo_q[1] ? rdata_q[15:0] : rdata_q[31:16];
        ld_signed = (op_q == OP_LB) || (op_q == OP_LH);
        case (op_size(op_q))
            SZ_B:    ld_data = {{24{ld_signed & byte_v[7]}}, byte_v};
            SZ_H:    ld_data = {{16{ld_signed & half_v[15]}}, half_v};
            default: ld_data = rdata_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        stb_d    = stb_q;
        addr_d   = addr_q;
        we_d     = we_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;
        op_d     = op_q;
        alo_d    = alo_q;
        stall    = 1'b0;
        wb_wreg  = ex_wreg;
        wb_whilo = ex_whilo;
        wb_wdata = ex_wdata;
        case (state_q)
            IDLE: begin
                if (is_mem && !flush) begin
                    wb_wreg = 1'b0;
                    if (misalign) begin
                        err_d = 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = REQ;
                        stb_d   = 1'b1;
                        addr_d  = {ex_mem_addr[31:2], 2'b00};
                        we_d    = !op_is_load(ex_aluop);
                        sel_d   = lane_sel;
                        wdata_d = st_data;
                        cnt_d   = '0;
                        op_d    = ex_aluop;
                        alo_d   = ex_mem_addr[1:0];
                    end
                end
            end
            REQ: begin
                stall   = 1'b1;
                wb_wreg = 1'b0;
                if (bus.bus_ack) begin
                    stb_d   = 1'b0;
                    rdata_d = bus.bus_rdata;
                    state_d = flush ? IDLE : DONE;
                end else if (timeout_hit) begin
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = flush ? IDLE : DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (flush) state_d = ABORT;
                end
            end
            ABORT: begin
                // The transfer in flight must still complete; its result is dropped.
                stall   = 1'b1;
                wb_wreg = 1'b0;
                if (bus.bus_ack) begin
                    stb_d   = 1'b0;
                    state_d = IDLE;
                end else if (timeout_hit) begin
                    stb_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                // err_q set here means the transfer timed out, so nothing is written back.
                wb_wreg = op_is_load(op_q) && ex_wreg && !err_q;
                if (op_is_load(op_q)) wb_wdata = ld_data;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            wb_wreg  = 1'b0;
            wb_whilo = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            stb_q   <= 1'b0;
            addr_q  <= 32'd0;
            we_q    <= 1'b0;
            sel_q   <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            op_q    <= 8'd0;
            alo_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            stb_q   <= stb_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            op_q    <= op_d;
            alo_q   <= alo_d;
        end
    end

    always_comb begin
        if (rst) begin
            mem_wd    = 5'd0;
            mem_wreg  = 1'b0;
            mem_wdata = 32'd0;
            mem_hi    = 32'd0;
            mem_lo    = 32'd0;
            mem_whilo = 1'b0;
            stallreq  = 1'b0;
        end else begin
            mem_wd    = ex_wd;
            mem_wreg  = wb_wreg;
            mem_wdata = wb_wdata;
            mem_hi    = ex_hi;
            mem_lo    = ex_lo;
            mem_whilo = wb_whilo;
            stallreq  = stall;
        end
    end

    // stb drops in the reset cycle itself, not one edge later.
    assign bus.bus_stb   = stb_q & ~rst;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_sel   = sel_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_err   = err_q;
    assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_mem_bus_stage.sv
// Self-checking bench for mem_bus_stage: transaction-level model, per-cycle expected queue,
// directed spec cases plus randomized load/store/ALU traffic with ACK_TIMEOUT = 4.
module tb_mem_bus_stage;
    localparam int T = 4;
    localparam logic [7:0] OP_ADD = 8'b0010_0000;
    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [4:0]  ex_wd = '0;
    logic        ex_wreg = 1'b0;
    logic [31:0] ex_wdata = '0, ex_hi = '0, ex_lo = '0, ex_mem_addr = '0, ex_reg2 = '0;
    logic        ex_whilo = 1'b0;
    logic [7:0]  ex_aluop = '0;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo, stallreq;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic [1:0]  dbg_state;

    mem_bus_if bus_if ();

    mem_bus_stage #(.ACK_TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
        .ex_whilo(ex_whilo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
        .mem_lo(mem_lo), .mem_whilo(mem_whilo), .stallreq(stallreq), .dbg_state_o(dbg_state),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        stall, stb, err, wreg, whilo, chk_bus, we, chk_data;
        logic [3:0]  sel;
        logic [31:0] addr, bwdata, wdata, hi, lo;
        logic [4:0]  wd;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic pend_err = 1'b0;

    int          seen_stb_n, seen_stall_n, seen_err_n, seen_wreg_n;
    logic [3:0]  seen_sel;
    logic [31:0] seen_addr, seen_bwdata, seen_wdata;
    logic        seen_we;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin : compare_blk
        exp_t e;
        if (stallreq === 1'b1) seen_stall_n = seen_stall_n + 1;
        if (bus_if.bus_err === 1'b1) seen_err_n = seen_err_n + 1;
        if (bus_if.bus_stb === 1'b1) begin
            seen_stb_n = seen_stb_n + 1;
            seen_sel = bus_if.bus_sel; seen_addr = bus_if.bus_addr;
            seen_bwdata = bus_if.bus_wdata; seen_we = bus_if.bus_we;
        end
        if (mem_wreg === 1'b1) begin
            seen_wreg_n = seen_wreg_n + 1;
            seen_wdata = mem_wdata;
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp("stallreq", stallreq, e.stall);
            cmp("bus_stb", bus_if.bus_stb, e.stb);
            cmp("bus_err", bus_if.bus_err, e.err);
            cmp("mem_wreg", mem_wreg, e.wreg);
            cmp("mem_whilo", mem_whilo, e.whilo);
            if (e.chk_bus) begin
                cmp("bus_addr", bus_if.bus_addr, e.addr);
                cmp("bus_we", bus_if.bus_we, e.we);
                cmp("bus_sel", bus_if.bus_sel, e.sel);
                cmp("bus_wdata", bus_if.bus_wdata, e.bwdata);
            end
            if (e.chk_data) begin
                cmp("mem_wd", mem_wd, e.wd);
                cmp("mem_wdata", mem_wdata, e.wdata);
                cmp("mem_hi", mem_hi, e.hi);
                cmp("mem_lo", mem_lo, e.lo);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input exp_t e);
        e.err = e.err | pend_err;
        pend_err = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic clear_seen();
        seen_stb_n = 0; seen_stall_n = 0; seen_err_n = 0; seen_wreg_n = 0;
        seen_sel = 'x; seen_addr = 'x; seen_bwdata = 'x; seen_wdata = 'x; seen_we = 1'bx;
    endtask

    // ---- behavioural model ----
    function automatic int op_bytes(input logic [7:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic bit is_load(input logic [7:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
    endfunction

    function automatic int lane_off(input logic [7:0] op, input logic [31:0] a);
        int n = op_bytes(op);
        if (n == 4) return 0;
        if (n == 2) return a[1] ? 2 : 0;
        return int'(a[1:0]);
    endfunction

    function automatic logic [3:0] m_sel(input logic [7:0] op, input logic [31:0] a);
        int n = op_bytes(op);
        int off = lane_off(op, a);
        return 4'(((1 << n) - 1) << (4 - off - n));
    endfunction

    function automatic logic [31:0] m_store(input logic [7:0] op, input logic [31:0] d);
        int n = op_bytes(op);
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        logic [63:0] r = '0;
        for (int i = 0; i < 4 / n; i++) r = r | ((64'(d) & mask) << (8 * n * i));
        return r[31:0];
    endfunction

    function automatic logic [31:0] m_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
        int n = op_bytes(op);
        int off = lane_off(op, a);
        logic [63:0] mask = (64'd1 << (8 * n)) - 64'd1;
        logic [63:0] v = (64'(d) >> (8 * (4 - off - n))) & mask;
        if ((op == OP_LB || op == OP_LH) && v[8 * n - 1]) v = v | ~mask;
        return v[31:0];
    endfunction

    function automatic bit m_misal(input logic [7:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_CHK_EN
        int n = op_bytes(op);
        return (n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00);
`else
        return (op == 8'hFF) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic exp_t row_pass();
        exp_t e = '0;
        e.wreg = ex_wreg && !flush; e.whilo = ex_whilo && !flush; e.chk_data = 1'b1;
        e.wd = ex_wd; e.wdata = ex_wdata; e.hi = ex_hi; e.lo = ex_lo;
        return e;
    endfunction

    // flush_at: cycle index (0 = issue cycle) carrying a one-cycle flush, -1 for none.
    // lat: ack arrives in REQ cycle number lat (0 = first REQ cycle); lat >= T never acks.
    task automatic run_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                          input logic wreg, input int flush_at, input int lat, input logic [31:0] rdata);
        int  n, ncyc, stb_end;
        bit  mem, tmo, mis, ld;
        exp_t e;
        n = op_bytes(op); mem = (n != 0); ld = is_load(op);
        mis = mem && (flush_at != 0) && m_misal(op, addr);
        tmo = mem && !mis && (flush_at != 0) && (lat >= T);
        stb_end = tmo ? T : 1 + lat;
        if (!mem || flush_at == 0 || mis) ncyc = 1;
        else if (tmo) ncyc = T + 2;
        else if (flush_at >= 1 && flush_at <= 1 + lat) ncyc = lat + 2;
        else ncyc = lat + 3;
        clear_seen();
        ex_aluop = op; ex_mem_addr = addr; ex_reg2 = reg2; ex_wreg = wreg;
        ex_wd = 5'($urandom_range(1, 31)); ex_wdata = $urandom(); ex_hi = $urandom(); ex_lo = $urandom();
        ex_whilo = mem ? 1'b0 : 1'($urandom_range(0, 1));
        for (int c = 0; c < ncyc; c++) begin
            flush = (c == flush_at);
            bus_if.bus_ack = mem && !tmo && !mis && (c == 1 + lat);
            bus_if.bus_rdata = bus_if.bus_ack ? rdata : $urandom();
            if (!mem) begin
                e = row_pass();
            end else begin
                e = '0;
                e.whilo = ex_whilo && !flush;
                e.wd = ex_wd; e.hi = ex_hi; e.lo = ex_lo;
                if (c == 0) begin
                    e.stall = !(flush_at == 0 || mis);
                end else if (c <= stb_end) begin
                    e.stall = 1'b1; e.stb = 1'b1; e.chk_bus = 1'b1;
                    e.addr = {addr[31:2], 2'b00}; e.we = !ld;
                    e.sel = m_sel(op, addr); e.bwdata = m_store(op, reg2);
                end else if (tmo) begin
                    e.err = 1'b1;
                end else if (ld && wreg && flush_at != c) begin
                    e.wreg = 1'b1; e.chk_data = 1'b1; e.wdata = m_load(op, addr, rdata);
                end
            end
            push(e);
            if (mis) pend_err = 1'b1;
            tick();
        end
        flush = 1'b0;
        bus_if.bus_ack = 1'b0;
    endtask

    logic [7:0] mem_ops [8] = '{OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

    initial begin
        exp_t e;
        int lat, fa;
        logic [7:0] op;
        bus_if.bus_ack = 1'b0;
        bus_if.bus_rdata = '0;
        clear_seen();

        tick();
        e = '0; e.chk_bus = 1'b1; e.chk_data = 1'b1;
        ex_aluop = OP_LW; ex_wreg = 1'b1; ex_wd = 5'd7; ex_wdata = 32'hDEAD_BEEF; ex_whilo = 1'b1;
        push(e);
        tick();
        cmp("reset_state", dbg_state, 2'd0);
        rst = 1'b0;

        run_op(OP_ADD, 32'h0, 32'h0, 1'b1, -1, 0, 32'h0);
        // ADD literal: same-cycle pass-through, no bus activity
        run_op(OP_ADD, 32'h0, 32'h0, 1'b1, -1, 0, 32'h0);
        ex_wdata = 32'h1234;
        e = row_pass(); push(e); tick();
        cmp("add_wdata", seen_wdata, 32'h1234);
        cmp("add_stb", seen_stb_n, 0);
        cmp("add_stall", seen_stall_n, 0);

        run_op(OP_LB, 32'h101, 32'h0, 1'b1, -1, 1, 32'h00F0_0000);
        cmp("lb_sel", seen_sel, 4'b0100);
        cmp("lb_wdata", seen_wdata, 32'hFFFF_FFF0);
        cmp("lb_stall", seen_stall_n, 3);

        run_op(OP_SH, 32'h202, 32'h0000_ABCD, 1'b1, -1, 0, 32'h0);
        cmp("sh_we", seen_we, 1'b1);
        cmp("sh_sel", seen_sel, 4'b0011);
        cmp("sh_wdata", seen_bwdata, 32'hABCD_ABCD);
        cmp("sh_addr", seen_addr, 32'h200);
        cmp("sh_wreg", seen_wreg_n, 0);

        run_op(OP_LW, 32'h400, 32'h0, 1'b1, 2, 3, 32'h1111_2222);
        cmp("lwfl_stb", seen_stb_n, 4);
        cmp("lwfl_wreg", seen_wreg_n, 0);
        cmp("lwfl_state", dbg_state, 2'd0);

        run_op(OP_LW, 32'h500, 32'h0, 1'b1, -1, 9, 32'h0);
        cmp("tmo_stb", seen_stb_n, T);
        cmp("tmo_err", seen_err_n, 1);
        cmp("tmo_wreg", seen_wreg_n, 0);

`ifdef MEM_ALIGN_CHK_EN
        run_op(OP_LW, 32'h3, 32'h0, 1'b1, -1, 0, 32'h0);
        cmp("mis_stb", seen_stb_n, 0);
        cmp("mis_stall", seen_stall_n, 0);
        run_op(OP_ADD, 32'h0, 32'h0, 1'b1, -1, 0, 32'h0);
        cmp("mis_err", seen_err_n, 1);
`endif

        // reset in the middle of a transfer, then an orphan ack while idle
        ex_aluop = OP_LW; ex_mem_addr = 32'h600; ex_wreg = 1'b1; ex_whilo = 1'b0;
        e = '0; e.stall = 1'b1; push(e); tick();
        e = '0; e.stall = 1'b1; e.stb = 1'b1; push(e); tick();
        rst = 1'b1;
        e = '0; e.chk_data = 1'b1; push(e); tick();
        rst = 1'b0;
        ex_aluop = OP_ADD; ex_wdata = 32'h55AA; bus_if.bus_ack = 1'b1;
        e = row_pass(); push(e); tick();
        bus_if.bus_ack = 1'b0;
        cmp("orphan_state", dbg_state, 2'd0);
        run_op(OP_LHU, 32'h702, 32'h0, 1'b1, -1, 0, 32'h8001_8765);
        cmp("lhu_wdata", seen_wdata, 32'h0000_8765);

        repeat (250) begin
            op = ($urandom_range(0, 9) < 3) ? OP_ADD : mem_ops[$urandom_range(0, 7)];
            lat = $urandom_range(0, 5);
            fa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lat + 2) : -1;
            if (lat >= T && fa > 0) fa = -1;
            run_op(op, $urandom(), $urandom(), 1'($urandom_range(0, 1)), fa, lat, $urandom());
        end

        tick();
        cmp("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
